// File: rtl/button_inst_decoder.sv
//----------------------------------------------------------------------------
// button_inst_decoder: synchronises, debounces and edge-detects the board
// pushbuttons, auto-repeats directions and issues one instruction per cycle.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module button_inst_decoder #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000,
  parameter int CNT_W           = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pause,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       move_lock,
  output logic       clk_en_d,
  output logic       inst_pause,
  output logic       inst_move,
  output logic [1:0] inst_dir
);

  localparam logic [CNT_W-1:0] c_db_max    = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] c_rep_delay = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] c_rep_per   = CNT_W'(REPEAT_PERIOD);

  // Bit order everywhere: 0 pause, 1 up, 2 down, 3 left, 4 right
  logic [4:0] w_raw;
  logic [4:0] r_sync1;
  logic [4:0] r_sync2;
  logic [4:0] r_deb;
  logic [4:0] r_deb_q;
  logic [4:0] w_press;
  logic [4:0] w_fire;
  logic [4:0] w_evt;
  logic [4:0] w_cand;

  logic       w_pause;
  logic       w_move;
  logic [1:0] w_dir;

  assign w_raw = {btn_right, btn_left, btn_down, btn_up, btn_pause};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb_q <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_btn
      logic [CNT_W-1:0] r_db_cnt;

      // Level flips only after the counter has sat at the limit with the
      // inputs still disagreeing, which yields the DEBOUNCE_CYCLES+3 latency.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_db_cnt  <= '0;
          r_deb[gi] <= 1'b0;
        end else if (r_sync2[gi] == r_deb[gi]) begin
          r_db_cnt <= '0;
        end else if (r_db_cnt == c_db_max) begin
          r_db_cnt  <= '0;
          r_deb[gi] <= r_sync2[gi];
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end

      assign w_press[gi] = r_deb[gi] & ~r_deb_q[gi];

      if (gi == 0) begin : g_norep
        assign w_fire[gi] = 1'b0;
      end else begin : g_rep
        logic [CNT_W-1:0] r_rep_cnt;
        logic             r_rep_first;
        logic [CNT_W-1:0] w_target;

        assign w_target   = r_rep_first ? c_rep_delay : c_rep_per;
        assign w_fire[gi] = r_deb[gi] & r_deb_q[gi] & (r_rep_cnt == w_target);

        always_ff @(posedge clk) begin
          if (rst || !r_deb[gi]) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
          end else if (w_press[gi]) begin
            r_rep_cnt   <= CNT_W'(1);
            r_rep_first <= 1'b1;
          end else if (w_fire[gi]) begin
            r_rep_cnt   <= CNT_W'(1);
            r_rep_first <= 1'b0;
          end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
          end
        end
      end
    end
  endgenerate

  assign w_evt  = w_press | w_fire;
  assign w_cand = w_evt & {{4{~move_lock}}, 1'b1};

  always_comb begin
    w_pause = 1'b0;
    w_move  = 1'b0;
    w_dir   = 2'b00;
    if (w_cand[0]) begin
      w_pause = 1'b1;
    end else if (w_cand[1]) begin
      w_move = 1'b1;
      w_dir  = 2'b00;
    end else if (w_cand[2]) begin
      w_move = 1'b1;
      w_dir  = 2'b01;
    end else if (w_cand[3]) begin
      w_move = 1'b1;
      w_dir  = 2'b10;
    end else if (w_cand[4]) begin
      w_move = 1'b1;
      w_dir  = 2'b11;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_en_d   <= 1'b0;
      inst_pause <= 1'b0;
      inst_move  <= 1'b0;
      inst_dir   <= 2'b00;
    end else begin
      clk_en_d   <= w_pause | w_move;
      inst_pause <= w_pause;
      inst_move  <= w_move;
      inst_dir   <= w_dir;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_button_inst_decoder.sv
//----------------------------------------------------------------------------
// tb_button_inst_decoder: directed stimulus with a queued expected-strobe
// scoreboard checked by an independent monitor.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_button_inst_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_pause = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       move_lock = 1'b0;
  logic       clk_en_d;
  logic       inst_pause;
  logic       inst_move;
  logic [1:0] inst_dir;

  button_inst_decoder #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8),
    .CNT_W          (26)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_pause (btn_pause),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .move_lock (move_lock),
    .clk_en_d  (clk_en_d),
    .inst_pause(inst_pause),
    .inst_move (inst_move),
    .inst_dir  (inst_dir)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    bit       p;
    bit       m;
    bit [1:0] d;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   base = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the head of the queue exactly
  always @(negedge clk) begin
    if (clk_en_d) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe cyc=%0d got p=%0b m=%0b d=%b, required none",
                 cyc, inst_pause, inst_move, inst_dir);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.p != inst_pause || e.m != inst_move || e.d != inst_dir) begin
          n_err++;
          $display("FAIL strobe got cyc=%0d p=%0b m=%0b d=%b, required cyc=%0d p=%0b m=%0b d=%b",
                   cyc, inst_pause, inst_move, inst_dir, e.cyc, e.p, e.m, e.d);
        end
      end
    end else if (inst_pause || inst_move || inst_dir != 2'b00) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_outputs cyc=%0d got p=%0b m=%0b d=%b, required all 0",
               cyc, inst_pause, inst_move, inst_dir);
    end
  end

  task automatic at(input int rel);
    while (cyc + 1 < base + rel) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_test();
    @(posedge clk);
    #1;
    base = cyc + 1;
  endtask

  task automatic expect_ev(input int rel, input bit p, input bit m, input bit [1:0] d);
    exp_t e;
    e.cyc = base + rel;
    e.p   = p;
    e.m   = m;
    e.d   = d;
    q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    n_vec++;
    if ({clk_en_d, inst_pause, inst_move, inst_dir} != 5'b0) begin
      n_err++;
      $display("FAIL %s got en=%0b p=%0b m=%0b d=%b, required all 0",
               name, clk_en_d, inst_pause, inst_move, inst_dir);
    end
  endtask

  task automatic check_drained(input string name);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL %s got %0d pending strobes, required 0", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst = 1'b0;

    // Pause press: single strobe at 7, nothing while held or on release
    start_test();
    expect_ev(7, 1, 0, 2'b00);
    btn_pause = 1'b1;
    at(20); btn_pause = 1'b0;
    at(40);
    check_drained("pause_press");

    // Glitches on up never survive debounce
    start_test();
    btn_up = 1'b1;
    at(3);  btn_up = 1'b0;
    at(6);  btn_up = 1'b1;
    at(9);  btn_up = 1'b0;
    at(30);
    check_drained("glitch");

    // Left held: press + auto-repeats, release stops further strobes
    start_test();
    expect_ev(7,  0, 1, 2'b10);
    expect_ev(27, 0, 1, 2'b10);
    expect_ev(35, 0, 1, 2'b10);
    expect_ev(43, 0, 1, 2'b10);
    btn_left = 1'b1;
    at(40); btn_left = 1'b0;
    at(70);
    check_drained("left_repeat");

    // Pause beats right; right's repeat timing unaffected; release at the repeat boundary
    start_test();
    expect_ev(7,  1, 0, 2'b00);
    expect_ev(27, 0, 1, 2'b11);
    btn_pause = 1'b1;
    btn_right = 1'b1;
    at(10); btn_pause = 1'b0;
    at(28); btn_right = 1'b0;
    at(60);
    check_drained("pause_vs_right");

    // Lock drops direction events but still delivers pause
    start_test();
    expect_ev(22, 1, 0, 2'b00);
    move_lock = 1'b1;
    btn_down  = 1'b1;
    at(15); btn_pause = 1'b1;
    at(40); btn_pause = 1'b0; btn_down = 1'b0;
    at(60); move_lock = 1'b0;
    at(70);
    check_drained("lock");

    // Reset mid-debounce aborts it; held button re-presses after reset
    start_test();
    expect_ev(13, 0, 1, 2'b00);
    btn_up = 1'b1;
    at(5);  rst = 1'b1;
    at(6);  rst = 1'b0;
    check_zero("in_reset");
    at(20); btn_up = 1'b0;
    at(45);
    check_drained("reset_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/button_inst_decoder.md
Name: button_inst_decoder

Overview:
- Front-end input stage of the game/stopwatch datapath: takes the raw, asynchronous board pushbuttons and turns them into clean single-cycle instruction strobes.
- Its outputs feed the stopwatch's pause toggle (clk_en_d with inst_pause) and the game-movement logic (clk_en_d with inst_move and inst_dir).
- Each button is synchronised, debounced and rising-edge detected.
- Direction buttons auto-repeat while held.
- Events arriving in the same cycle are arbitrated into at most one instruction per cycle.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before the debounced level changes (10 ms at 100 MHz).
- REPEAT_DELAY, 50000000, cycles from the press event to the first auto-repeat event.
- REPEAT_PERIOD, 20000000, cycles between subsequent auto-repeat events.
- CNT_W, 26, width of the debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- btn_pause  in  1  raw pause button, asynchronous
- btn_up  in  1  raw up button, asynchronous
- btn_down  in  1  raw down button, asynchronous
- btn_left  in  1  raw left button, asynchronous
- btn_right  in  1  raw right button, asynchronous
- move_lock  in  1  when high, direction events are discarded (driven from game-over)
- clk_en_d  out  1  one-cycle instruction-valid strobe
- inst_pause  out  1  pause instruction; high only together with clk_en_d
- inst_move  out  1  move instruction; high only together with clk_en_d
- inst_dir  out  2  direction, valid only with inst_move: 00 up, 01 down, 10 left, 11 right; 00 otherwise

Behaviour:
- Reset (rst high at a clk edge):
  - All outputs go to 0.
  - Synchroniser flops, debounced levels, debounce counters and repeat counters all clear to 0.
  - Reset asserted mid-debounce or mid-repeat aborts that debounce or repeat with no event.
  - A button held through reset release is treated as a new press and yields exactly one event after the normal latency.
- Synchroniser: two flops per button; all downstream logic uses only the second flop's output.
- Debounce, per button:
  - Counter increments each cycle the synchronised level differs from the debounced level.
  - Counter clears to 0 whenever the two levels match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronised value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never change the debounced level.
- Press event: debounced level 0->1.
- Release: debounced 1->0; produces no event.
- Latency: clk_en_d is high exactly DEBOUNCE_CYCLES+3 cycles after the first clk edge that samples the raw input high, given the raw input stays high throughout.
- Auto-repeat, direction buttons only:
  - The repeat counter starts at the press event.
  - A repeat event fires REPEAT_DELAY cycles after the press event.
  - Further repeat events fire every REPEAT_PERIOD cycles while the debounced level stays 1.
  - Release clears the counter immediately; no repeat fires in the cycle the debounced level falls.
  - btn_pause never repeats.
- Arbitration, per cycle:
  - Candidate events (press or repeat) have fixed priority: pause > up > down > left > right.
  - Only the winner is issued; losing events are dropped, not queued.
  - Repeat timing of a losing button continues unaffected.
- Lock:
  - While move_lock is high, direction events are removed before arbitration, so a locked direction never blocks anything.
  - Pause is still delivered while locked.
  - Lock does not stop debounce or repeat counting.
- Output stage:
  - Outputs are registered from the arbitration result, giving 1 cycle of arbitration latency (included in the DEBOUNCE_CYCLES+3 figure).
  - clk_en_d is never high in two consecutive cycles caused by the same press.
  - When clk_en_d is 0, inst_pause, inst_move and inst_dir are all 0.
  - inst_pause and inst_move are never both 1.
- Counters saturate-free: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD are each ≥ 2, and the counters never wrap in legal use.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
1. Raw btn_pause rises and holds; first sampling edge = cycle 0 → clk_en_d=1 and inst_pause=1 only in cycle 7; no further strobes while held; release produces no strobe.
2. btn_up toggles 1,0,1,0 with 3-cycle high pulses, then stays low → no strobe ever; debounced level stays 0.
3. btn_left held, press strobe in cycle 7 → inst_move=1, inst_dir=10 at cycles 7, 27, 35, 43; release at cycle 40 (debounced falls at cycle 46) → no strobe after 43.
4. btn_pause and btn_right rise in the same cycle → single strobe with inst_pause=1 at cycle 7; no right event; right's repeat still fires at cycle 27 with inst_dir=11.
5. move_lock=1 with btn_down pressed → no strobe; btn_pause pressed while still locked → pause strobe delivered.
6. btn_up held, rst pulsed for 1 cycle at cycle 5 (mid-debounce) → no strobe before reset; exactly one strobe (inst_dir=00) DEBOUNCE_CYCLES+3 cycles after the first post-reset sample; all outputs 0 during reset.
